// File: rtl/mvm_stream_feeder.sv
// Streams a stored N*N+2N word frame (A, B, X) rpt times per start; first word 2 cycles after start.
// One word per cycle under m_ready; the output register holds its word while the sink stalls.
module mvm_stream_feeder #(
   parameter int N = 3,
   localparam int FRAME = N*N + 2*N,
   localparam int AW = $clog2(FRAME)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_wr_en,
   input  logic [AW-1:0]        cfg_addr,
   input  logic signed [7:0]    cfg_data,
   input  logic                 start,
   input  logic [3:0]           rpt,
   output logic signed [7:0]    data_out,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_X, DONE} state_t;

   localparam logic [AW-1:0] LAST_A = AW'(N*N - 1);
   localparam logic [AW-1:0] LAST_B = AW'(N*N + N - 1);
   localparam logic [AW-1:0] LAST_X = AW'(FRAME - 1);

   state_t            state_q;
   logic signed [7:0] mem_q [FRAME];
   logic [AW-1:0]     wcnt_q;
   logic [AW-1:0]     fptr_q;
   logic [3:0]        fcnt_q;
   logic [3:0]        ffcnt_q;
   logic [3:0]        rpt_q;
   logic              fetch_q;
   logic signed [7:0] data_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

   logic hs_d;
   logic load_d;
   logic wr_d;
   logic fetch_last_d;
   logic frame_last_d;

   assign hs_d         = valid_q && m_ready;
   assign load_d       = fetch_q && (!valid_q || m_ready);
   assign wr_d         = cfg_wr_en && !busy_q && (int'(cfg_addr) < FRAME);
   assign fetch_last_d = ({1'b0, ffcnt_q} + 5'd1) == {1'b0, rpt_q};
   assign frame_last_d = ({1'b0, fcnt_q} + 5'd1) == {1'b0, rpt_q};

   assign data_out = data_q;
   assign m_valid  = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

   // Buffer contents are deliberately not reset; writes are only accepted while idle.
   always_ff @(posedge clk) begin
      if (wr_d) begin
         mem_q[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         fptr_q  <= '0;
         fcnt_q  <= '0;
         ffcnt_q <= '0;
         rpt_q   <= '0;
         fetch_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // Fetch side runs ahead of the handshake side by at most the one output register.
         if (load_d) begin
            data_q  <= mem_q[fptr_q];
            valid_q <= 1'b1;
            if (fptr_q == LAST_X) begin
               fptr_q <= '0;
               if (fetch_last_d) begin
                  fetch_q <= 1'b0;
               end else begin
                  ffcnt_q <= ffcnt_q + 4'd1;
               end
            end else begin
               fptr_q <= fptr_q + AW'(1);
            end
         end else if (hs_d) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SEND_A;
                  busy_q  <= 1'b1;
                  fetch_q <= 1'b1;
                  fptr_q  <= '0;
                  ffcnt_q <= '0;
                  wcnt_q  <= '0;
                  fcnt_q  <= '0;
                  rpt_q   <= (rpt == 4'd0) ? 4'd1 : rpt;
               end
            end
            SEND_A: begin
               if (hs_d) begin
                  wcnt_q <= wcnt_q + AW'(1);
                  if (wcnt_q == LAST_A) begin
                     state_q <= SEND_B;
                  end
               end
            end
            SEND_B: begin
               if (hs_d) begin
                  wcnt_q <= wcnt_q + AW'(1);
                  if (wcnt_q == LAST_B) begin
                     state_q <= SEND_X;
                  end
               end
            end
            SEND_X: begin
               if (hs_d) begin
                  if (wcnt_q == LAST_X) begin
                     wcnt_q <= '0;
                     if (frame_last_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        fcnt_q  <= fcnt_q + 4'd1;
                        state_q <= SEND_A;
                     end
                  end else begin
                     wcnt_q <= wcnt_q + AW'(1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   hold_stable_a: assert property (@(posedge clk) disable iff (reset)
      (valid_q && !m_ready) |=> (valid_q && $stable(data_q)));

endmodule

// File: tb/tb_mvm_stream_feeder.sv
// Scoreboard bench for mvm_stream_feeder: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_mvm_stream_feeder;
   localparam int N = 3;
   localparam int FRAME = N*N + 2*N;
   localparam int AW = $clog2(FRAME);

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_wr_en;
   logic [AW-1:0]     cfg_addr;
   logic signed [7:0] cfg_data;
   logic              start;
   logic [3:0]        rpt;
   logic signed [7:0] data_out;
   logic              m_valid;
   logic              m_ready;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   mvm_stream_feeder #(.N(N)) dut (
      .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start(start), .rpt(rpt), .data_out(data_out),
      .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int done_cnt = 0;
   logic signed [7:0] model_mem [FRAME];
   logic signed [7:0] exp_q [$];
   bit prev_stall = 1'b0;
   bit prev_last = 1'b0;
   logic signed [7:0] prev_data = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stall hold and done timing.
   always @(negedge clk) begin
      bit last_now;
      logic signed [7:0] e;
      last_now = 1'b0;
      if (reset) begin
         prev_stall = 1'b0;
         prev_last  = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", int'(m_valid), 1);
            chk("hold_data", int'(data_out), int'(prev_data));
         end
         if (m_valid && m_ready) begin
            chk("word_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("stream_word", int'(data_out), int'(e));
               last_now = (exp_q.size() == 0);
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_after_last", int'(prev_last), 1);
         end
         if (!busy) chk("idle_valid_low", int'(m_valid), 0);
         prev_last  = last_now;
         prev_stall = m_valid && !m_ready;
         prev_data  = data_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int a, input int d);
      cfg_wr_en = 1'b1;
      cfg_addr  = AW'(a);
      cfg_data  = 8'(d);
      if (a < FRAME) model_mem[a] = 8'(d);
      tick();
      cfg_wr_en = 1'b0;
   endtask

   // Start pulse; the expected stream is the buffer image rpt times (0 means once).
   task automatic launch(input int r, input bit with_wr = 1'b0, input int a = 0, input int d = 0);
      int eff;
      if (with_wr) begin
         cfg_wr_en = 1'b1;
         cfg_addr  = AW'(a);
         cfg_data  = 8'(d);
         if (a < FRAME) model_mem[a] = 8'(d);
      end
      start = 1'b1;
      rpt   = 4'(r);
      eff   = (r == 0) ? 1 : r;
      for (int f = 0; f < eff; f++)
         for (int i = 0; i < FRAME; i++)
            exp_q.push_back(model_mem[i]);
      tick();
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      rpt       = 4'($urandom_range(0, 15));
   endtask

   // Called right after launch with m_ready high: checks 2-cycle latency, no bubbles and the done cycle.
   task automatic run_contig(input int nwords);
      @(negedge clk);
      chk("lat_not_early", int'(m_valid), 0);
      for (int k = 0; k < nwords; k++) begin
         @(negedge clk);
         chk("stream_no_bubble", int'(m_valid), 1);
      end
      @(negedge clk);
      chk("done_pulse", int'(done), 1);
      chk("valid_low_in_done", int'(m_valid), 0);
      chk("busy_in_done", int'(busy), 1);
      @(negedge clk);
      chk("busy_clear", int'(busy), 0);
      chk("done_single", int'(done), 0);
      tick();
      chk("sb_drained", exp_q.size(), 0);
   endtask

   task automatic wait_idle(input bit rnd_bp, input bit noise);
      int c;
      c = 0;
      while (busy && c < 3000) begin
         if (rnd_bp) m_ready = ($urandom_range(0, 3) != 0);
         if (noise) begin
            start     = 1'($urandom_range(0, 1));
            cfg_wr_en = 1'($urandom_range(0, 1));
            cfg_addr  = AW'($urandom_range(0, 15));
            cfg_data  = 8'($urandom_range(0, 255));
         end
         tick();
         c++;
      end
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      m_ready   = 1'b1;
      chk("idle_reached", (c < 3000) ? 1 : 0, 1);
      tick();
      chk("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      int d0;
      reset = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0;
      start = 1'b0; rpt = '0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_data", int'(data_out), 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < FRAME; i++) cfg_write(i, i + 1);

      d0 = done_cnt; launch(1); run_contig(FRAME);
      chk("done_count_single", done_cnt - d0, 1);

      // Backpressure on the word of value 5.
      d0 = done_cnt; launch(1);
      repeat (5) tick();
      m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid", int'(m_valid), 1);
         chk("bp_data", int'(data_out), 5);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_idle(1'b0, 1'b0);
      chk("done_count_bp", done_cnt - d0, 1);

      d0 = done_cnt; launch(2); run_contig(2 * FRAME);
      chk("done_count_rpt2", done_cnt - d0, 1);

      d0 = done_cnt; launch(0); run_contig(FRAME);
      chk("done_count_rpt0", done_cnt - d0, 1);

      cfg_write(0, -128); cfg_write(14, 127);
      launch(1); run_contig(FRAME);
      cfg_write(0, 1); cfg_write(14, 15);

      // Start and write while busy must both be ignored.
      d0 = done_cnt; launch(2);
      repeat (4) tick();
      start = 1'b1; rpt = 4'd5; cfg_wr_en = 1'b1; cfg_addr = '0; cfg_data = 8'sd99;
      tick();
      start = 1'b0; cfg_wr_en = 1'b0;
      wait_idle(1'b0, 1'b0);
      chk("done_count_guard", done_cnt - d0, 1);

      cfg_write(15, 55);
      launch(1, 1'b1, 3, -7); run_contig(FRAME);

      // Async reset while word 7 is on the output.
      launch(1);
      repeat (7) tick();
      chk("pre_reset_word", int'(data_out), 7);
      reset = 1'b1;
      #1;
      chk("arst_valid", int'(m_valid), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_reset_quiet", int'(m_valid | busy), 0);
      end
      tick();
      launch(1); run_contig(FRAME);

      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < FRAME; i++) cfg_write(i, int'($urandom_range(0, 255)) - 128);
         d0 = done_cnt;
         launch(int'($urandom_range(0, 3)));
         wait_idle(1'b1, 1'b1);
         chk("done_count_rand", done_cnt - d0, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
